// File: rtl/fetch_decode_controller_pkg.sv
// Shared definitions for the fetch/decode/sequence controller: FSM state
// codes, opcode/ext encodings, write-back bus and shifter codes, and the
// instruction class enumeration produced by the decoder.
package fetch_decode_controller_pkg;

  // Controller states (legacy-compatible constants)
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_PCUP   = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  // Primary opcodes, IR[15:12]
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ANDI  = 4'b0001;
  localparam logic [3:0] OP_XORI  = 4'b0010;
  localparam logic [3:0] OP_ORI   = 4'b0011;
  localparam logic [3:0] OP_SPEC  = 4'b0100;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_SHIFT = 4'b1000;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_MOVI  = 4'b1101;
  localparam logic [3:0] OP_LUI   = 4'b1111;

  // R-type ext codes share the ALU operation numbering with the I-type opcodes
  localparam logic [3:0] EXT_AND  = 4'b0001;
  localparam logic [3:0] EXT_XOR  = 4'b0010;
  localparam logic [3:0] EXT_OR   = 4'b0011;
  localparam logic [3:0] EXT_ADD  = 4'b0101;
  localparam logic [3:0] EXT_SUB  = 4'b1001;
  localparam logic [3:0] EXT_CMP  = 4'b1011;
  localparam logic [3:0] EXT_MOV  = 4'b1101;

  // ext codes under OP_SPEC
  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  // Write-back bus select
  localparam logic [2:0] BUS_ALU   = 3'd0;
  localparam logic [2:0] BUS_SHIFT = 3'd1;
  localparam logic [2:0] BUS_MEM   = 3'd2;
  localparam logic [2:0] BUS_IMM   = 3'd3;
  localparam logic [2:0] BUS_PC    = 3'd4;
  localparam logic [2:0] BUS_REGB  = 3'd5;

  // Shifter operations, taken from ext[1:0]
  localparam logic [1:0] SH_LSL = 2'd0;
  localparam logic [1:0] SH_LSR = 2'd1;
  localparam logic [1:0] SH_ASR = 2'd2;
  localparam logic [1:0] SH_ROL = 2'd3;

  typedef enum logic [2:0] {
    CLS_ALU   = 3'd0,
    CLS_SHIFT = 3'd1,
    CLS_LOAD  = 3'd2,
    CLS_STOR  = 3'd3,
    CLS_JCOND = 3'd4,
    CLS_BCOND = 3'd5,
    CLS_WAIT  = 3'd6,
    CLS_UNDEF = 3'd7
  } instr_class_t;

  // ALU operations that update the condition flags (ADD/SUB/CMP and immediates)
  function automatic logic is_flag_op(input logic [3:0] code);
    return (code == EXT_ADD) || (code == EXT_SUB) || (code == EXT_CMP);
  endfunction

endpackage

// File: rtl/fetch_decode_controller_instr_decoder.sv
// Purely combinational instruction decoder: classifies the IR and produces
// the extended immediate, ALU/shift operations, bus select and the write
// enables that the sequencer applies during EXEC.
module fetch_decode_controller_instr_decoder
  import fetch_decode_controller_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_ir,
  output instr_class_t     o_cls,
  output logic [WIDTH-1:0] o_immediate,
  output logic [3:0]       o_alu_op,
  output logic [1:0]       o_shift_op,
  output logic [2:0]       o_bus_op,
  output logic             o_imm_mux,
  output logic             o_reg_wr,
  output logic             o_flag_wr
);

  logic [3:0] w_op;
  logic [3:0] w_ext;
  logic [7:0] w_imm8;

  assign w_op   = i_ir[15:12];
  assign w_ext  = i_ir[7:4];
  assign w_imm8 = i_ir[7:0];

  // Decode IR into class, operand controls and extended immediate
  always_comb begin
    o_cls       = CLS_UNDEF;
    o_immediate = WIDTH'(w_imm8);
    o_alu_op    = 4'h0;
    o_shift_op  = SH_LSL;
    o_bus_op    = BUS_ALU;
    o_imm_mux   = 1'b0;
    o_reg_wr    = 1'b0;
    o_flag_wr   = 1'b0;
    if (i_ir == '0) begin
      o_cls = CLS_WAIT;
    end else begin
      case (w_op)
        OP_RTYPE: begin
          case (w_ext)
            EXT_AND, EXT_XOR, EXT_OR, EXT_ADD, EXT_SUB, EXT_CMP, EXT_MOV: begin
              o_cls     = CLS_ALU;
              o_alu_op  = w_ext;
              o_flag_wr = is_flag_op(w_ext);
              o_reg_wr  = (w_ext != EXT_CMP);
            end
            default: o_cls = CLS_UNDEF;
          endcase
        end
        OP_SPEC: begin
          case (w_ext)
            EXT_LOAD: begin
              o_cls    = CLS_LOAD;
              o_bus_op = BUS_MEM;
            end
            EXT_STOR:  o_cls = CLS_STOR;
            EXT_JCOND: o_cls = CLS_JCOND;
            default:   o_cls = CLS_UNDEF;
          endcase
        end
        OP_SHIFT: begin
          // ext[2] is reserved; ext[3] picks immediate vs register shift amount
          if (w_ext[2] == 1'b0) begin
            o_cls      = CLS_SHIFT;
            o_shift_op = w_ext[1:0];
            o_imm_mux  = w_ext[3];
            o_bus_op   = BUS_SHIFT;
            o_reg_wr   = 1'b1;
          end else begin
            o_cls = CLS_UNDEF;
          end
        end
        OP_BCOND: begin
          o_cls       = CLS_BCOND;
          o_immediate = {{(WIDTH-8){w_imm8[7]}}, w_imm8};
        end
        OP_ANDI, OP_XORI, OP_ORI, OP_MOVI: begin
          o_cls     = CLS_ALU;
          o_alu_op  = w_op;
          o_imm_mux = 1'b1;
          o_reg_wr  = 1'b1;
        end
        OP_ADDI, OP_SUBI, OP_CMPI: begin
          o_cls       = CLS_ALU;
          o_alu_op    = w_op;
          o_imm_mux   = 1'b1;
          o_immediate = {{(WIDTH-8){w_imm8[7]}}, w_imm8};
          o_flag_wr   = 1'b1;
          o_reg_wr    = (w_op != OP_CMPI);
        end
        OP_LUI: begin
          o_cls       = CLS_ALU;
          o_alu_op    = w_op;
          o_imm_mux   = 1'b1;
          o_immediate = WIDTH'({w_imm8, 8'h00});
          o_bus_op    = BUS_IMM;
          o_reg_wr    = 1'b1;
        end
        default: o_cls = CLS_UNDEF;
      endcase
    end
  end

endmodule

// File: rtl/fetch_decode_controller.sv
// Multicycle fetch/decode/sequence controller for the 16-bit datapath.
// Sequence: FETCH -> DECODE -> EXEC -> [MEM] -> PCUP -> FETCH; IR==0 halts.
// Optional macro ILLEGAL_TRAP_EN: undefined encodings enter an absorbing TRAP
// state with illegal=1; without it they run as a NOP (EXEC, then pcAdd).
module fetch_decode_controller
  import fetch_decode_controller_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int REGBITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   instr_in,
  input  logic               instr_valid,
  input  logic               mem_valid,
  output logic               fetch_req,
  output logic [7:0]         instructionOp,
  output logic [WIDTH-1:0]   immediate,
  output logic [REGBITS-1:0] regAddA,
  output logic [REGBITS-1:0] regAddB,
  output logic [3:0]         ALUOp,
  output logic [1:0]         shiftOp,
  output logic [2:0]         busOp,
  output logic               immMUX,
  output logic               regWrite,
  output logic               memWrite,
  output logic [3:0]         flagOp,
  output logic               flagWrite,
  output logic               pcAdd,
  output logic               pcJump,
  output logic               pcBranch,
  output logic               halted,
  output logic               illegal
);

  logic [2:0]       r_state;
  logic [2:0]       w_next_state;
  logic [WIDTH-1:0] r_ir;

  instr_class_t     w_cls;
  logic             w_dec_reg_wr;
  logic             w_dec_flag_wr;
  logic             w_reg_write;
  logic             w_mem_write;
  logic             w_flag_write;
  logic             w_pc_add;
  logic             w_pc_jump;
  logic             w_pc_branch;

`ifdef ILLEGAL_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
  assign illegal = (r_state == S_TRAP);
`else
  localparam logic TRAP_EN = 1'b0;
  assign illegal = 1'b0;
`endif

  fetch_decode_controller_instr_decoder #(
    .WIDTH (WIDTH)
  ) u_instr_decoder (
    .i_ir        (r_ir),
    .o_cls       (w_cls),
    .o_immediate (immediate),
    .o_alu_op    (ALUOp),
    .o_shift_op  (shiftOp),
    .o_bus_op    (busOp),
    .o_imm_mux   (immMUX),
    .o_reg_wr    (w_dec_reg_wr),
    .o_flag_wr   (w_dec_flag_wr)
  );

  // Field outputs come straight from the IR, so they hold from DECODE to PCUP
  assign instructionOp = r_ir[15:8];
  assign regAddA       = r_ir[REGBITS-1:0];
  assign regAddB       = r_ir[8 +: REGBITS];
  assign flagOp        = r_ir[11:8];
  assign fetch_req     = (r_state == S_FETCH);
  assign halted        = (r_state == S_HALT);

  // Next-state sequencing
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH: begin
        if (instr_valid) w_next_state = S_DECODE;
        else             w_next_state = S_FETCH;
      end
      S_DECODE: begin
        if (w_cls == CLS_WAIT)                      w_next_state = S_HALT;
        else if ((w_cls == CLS_UNDEF) && TRAP_EN)   w_next_state = S_TRAP;
        else                                        w_next_state = S_EXEC;
      end
      S_EXEC: begin
        if ((w_cls == CLS_LOAD) || (w_cls == CLS_STOR)) w_next_state = S_MEM;
        else                                            w_next_state = S_PCUP;
      end
      S_MEM: begin
        if (w_cls == CLS_STOR) w_next_state = S_PCUP;
        else if (mem_valid)    w_next_state = S_PCUP;
        else                   w_next_state = S_MEM;
      end
      S_PCUP:  w_next_state = S_FETCH;
      S_HALT:  w_next_state = S_HALT;
      S_TRAP:  w_next_state = S_TRAP;
      default: w_next_state = S_FETCH;
    endcase
  end

  // State and instruction register; IR only loads on an accepted fetch
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_ir    <= '0;
    end else begin
      r_state <= w_next_state;
      if ((r_state == S_FETCH) && instr_valid) begin
        r_ir <= instr_in;
      end
    end
  end

  // Per-state strobe generation
  always_comb begin
    w_reg_write  = 1'b0;
    w_mem_write  = 1'b0;
    w_flag_write = 1'b0;
    w_pc_add     = 1'b0;
    w_pc_jump    = 1'b0;
    w_pc_branch  = 1'b0;
    case (r_state)
      S_EXEC: begin
        if ((w_cls == CLS_ALU) || (w_cls == CLS_SHIFT)) begin
          w_reg_write  = w_dec_reg_wr;
          w_flag_write = w_dec_flag_wr;
        end else begin
          w_reg_write  = 1'b0;
          w_flag_write = 1'b0;
        end
      end
      S_MEM: begin
        if (w_cls == CLS_STOR)  w_mem_write = 1'b1;
        else if (mem_valid)     w_reg_write = 1'b1;
        else                    w_reg_write = 1'b0;
      end
      S_PCUP: begin
        if (w_cls == CLS_JCOND)      w_pc_jump   = 1'b1;
        else if (w_cls == CLS_BCOND) w_pc_branch = 1'b1;
        else                         w_pc_add    = 1'b1;
      end
      default: w_reg_write = 1'b0;
    endcase
  end

  // Strobes are blocked while reset is low so an aborted sequence commits nothing
  assign regWrite  = w_reg_write  & reset;
  assign memWrite  = w_mem_write  & reset;
  assign flagWrite = w_flag_write & reset;
  assign pcAdd     = w_pc_add     & reset;
  assign pcJump    = w_pc_jump    & reset;
  assign pcBranch  = w_pc_branch  & reset;

endmodule
